// File: rtl/pid_compute_core_pkg.sv
// Shared types and widths for the PID compute core.
// Imported by the interface, the saturator and the top.
package pid_compute_core_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ERR,
        MUL_P,
        MUL_I,
        MUL_D,
        OUT
    } state_t;

    localparam int GAIN_W  = 6;
    localparam int IN_W    = 8;
    localparam int ERR_W   = 9;
    localparam int DER_W   = 10;
    localparam int INT_W   = 11;
    localparam int ACC_W   = 20;
    localparam int OUT_W   = 8;
    localparam int OUT_MAX = 255;
    localparam int PROD_W  = GAIN_W + 1 + INT_W;

endpackage

// File: rtl/pid_compute_core_if.sv
// Sample request / result bundle between controller and PID core.
// master drives requests, slave is the compute core.
interface pid_compute_core_if;
    import pid_compute_core_pkg::*;

    logic              sample_req;
    logic [IN_W-1:0]   setpoint;
    logic [IN_W-1:0]   measurement;
    logic [GAIN_W-1:0] K_p;
    logic [GAIN_W-1:0] K_i;
    logic [GAIN_W-1:0] K_d;
    logic [OUT_W-1:0]  pid_out;
    logic              out_valid;
    logic              busy;
    logic              overrun;

    modport master (
        output sample_req, setpoint, measurement, K_p, K_i, K_d,
        input  pid_out, out_valid, busy, overrun
    );

    modport slave (
        input  sample_req, setpoint, measurement, K_p, K_i, K_d,
        output pid_out, out_valid, busy, overrun
    );

endinterface

// File: rtl/pid_compute_core_sat_clamp.sv
// Combinational signed saturator: clamps din into [LO, HI]
// and truncates to OUT_W bits (used for integrator and output).
module pid_sat_clamp #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 11,
    parameter int LO    = -511,
    parameter int HI    = 511
) (
    input  logic signed [IN_W-1:0] din,
    output logic [OUT_W-1:0]       dout
);

    localparam logic signed [IN_W-1:0] LO_I = IN_W'(LO);
    localparam logic signed [IN_W-1:0] HI_I = IN_W'(HI);
    localparam logic [OUT_W-1:0]       LO_O = OUT_W'(LO);
    localparam logic [OUT_W-1:0]       HI_O = OUT_W'(HI);

    always_comb begin
        dout = din[OUT_W-1:0];
        if (din < LO_I) begin
            dout = LO_O;
        end else if (din > HI_I) begin
            dout = HI_O;
        end
    end

endmodule

// File: rtl/pid_compute_core.sv
// Discrete PID update with one shared multiplier, 5-cycle latency.
// Gains and inputs are snapshotted when a request is accepted.
module pid_compute_core
    import pid_compute_core_pkg::*;
#(
    parameter int FRAC_BITS = 2,
    parameter int INT_LIM   = 511
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    pid_compute_core_if.slave bus
);

    state_t state_q, state_d;

    logic [IN_W-1:0]          sp_q, meas_q;
    logic [GAIN_W-1:0]        kp_q, ki_q, kd_q;
    logic signed [ERR_W-1:0]  e_q, prev_q;
    logic signed [DER_W-1:0]  d_q;
    logic signed [INT_W-1:0]  integ_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [OUT_W-1:0]         pid_q;
    logic                     overrun_q;

    logic signed [ERR_W-1:0]  e_cur;
    logic signed [DER_W-1:0]  d_cur;
    logic signed [INT_W:0]    integ_sum;
    logic [INT_W-1:0]         integ_clamp;
    logic [GAIN_W-1:0]        gain;
    logic signed [GAIN_W:0]   gain_s;
    logic signed [INT_W-1:0]  opnd;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_nxt;
    logic signed [ACC_W-1:0]  acc_sh;
    logic [OUT_W-1:0]         sat_out;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else if (ena) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.sample_req) state_d = ERR;
            ERR:     state_d = MUL_P;
            MUL_P:   state_d = MUL_I;
            MUL_I:   state_d = MUL_D;
            MUL_D:   state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign e_cur = $signed({1'b0, sp_q}) - $signed({1'b0, meas_q});
    assign d_cur = DER_W'(e_cur) - DER_W'(prev_q);
    assign integ_sum = (INT_W+1)'(integ_q) + (INT_W+1)'(e_cur);

    pid_sat_clamp #(
        .IN_W(INT_W + 1), .OUT_W(INT_W),
        .LO(-INT_LIM), .HI(INT_LIM)
    ) u_int_clamp (
        .din(integ_sum), .dout(integ_clamp)
    );

    // One multiplier, operand pair chosen by the current phase
    always_comb begin
        gain = '0;
        opnd = '0;
        unique case (state_q)
            MUL_P: begin gain = kp_q; opnd = INT_W'(e_q); end
            MUL_I: begin gain = ki_q; opnd = integ_q; end
            MUL_D: begin gain = kd_q; opnd = INT_W'(d_q); end
            default: ;
        endcase
    end

    assign gain_s  = $signed({1'b0, gain});
    assign prod    = gain_s * opnd;
    assign acc_nxt = acc_q + ACC_W'(prod);
    assign acc_sh  = acc_nxt >>> FRAC_BITS;

    pid_sat_clamp #(
        .IN_W(ACC_W), .OUT_W(OUT_W),
        .LO(0), .HI(OUT_MAX)
    ) u_out_clamp (
        .din(acc_sh), .dout(sat_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp_q      <= '0;
            meas_q    <= '0;
            kp_q      <= '0;
            ki_q      <= '0;
            kd_q      <= '0;
            e_q       <= '0;
            prev_q    <= '0;
            d_q       <= '0;
            integ_q   <= '0;
            acc_q     <= '0;
            pid_q     <= '0;
            overrun_q <= 1'b0;
        end else if (ena) begin
            overrun_q <= bus.sample_req && (state_q != IDLE);
            unique case (state_q)
                IDLE: if (bus.sample_req) begin
                    sp_q   <= bus.setpoint;
                    meas_q <= bus.measurement;
                    kp_q   <= bus.K_p;
                    ki_q   <= bus.K_i;
                    kd_q   <= bus.K_d;
                end
                ERR: begin
                    e_q     <= e_cur;
                    d_q     <= d_cur;
                    prev_q  <= e_cur;
                    integ_q <= $signed(integ_clamp);
                    acc_q   <= '0;
                end
                MUL_P, MUL_I: acc_q <= acc_nxt;
                // Register the result here so it is stable during OUT
                MUL_D: begin
                    acc_q <= acc_nxt;
                    pid_q <= sat_out;
                end
                default: ;
            endcase
        end else begin
            overrun_q <= 1'b0;
        end
    end

    assign bus.pid_out   = pid_q;
    assign bus.out_valid = ena && (state_q == OUT);
    assign bus.busy      = (state_q != IDLE);
    assign bus.overrun   = ena && overrun_q;

endmodule

// File: tb/tb_pid_compute_core.sv
// Scoreboard bench for pid_compute_core: expected results queued
// at issue, compared by a monitor on out_valid / overrun pulses.
module tb_pid_compute_core;

    logic clk = 1'b0;
    logic rst_n;
    logic ena;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;

    typedef struct {
        logic [7:0] v;
        int         c;
    } exp_t;

    exp_t expq[$];
    int   ovq[$];

    pid_compute_core_if bus();

    pid_compute_core dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", n, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid) begin
                checks++;
                if (expq.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_valid actual=%0d cyc=%0d required=none",
                             bus.pid_out, cyc);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    if (bus.pid_out !== e.v || cyc != e.c) begin
                        fails++;
                        $display("FAIL pid_out actual=%0d@%0d required=%0d@%0d",
                                 bus.pid_out, cyc, e.v, e.c);
                    end
                end
            end
            if (bus.overrun) begin
                checks++;
                if (ovq.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_overrun actual=cyc%0d required=none", cyc);
                end else begin
                    int oc;
                    oc = ovq.pop_front();
                    if (cyc != oc) begin
                        fails++;
                        $display("FAIL overrun_cycle actual=%0d required=%0d", cyc, oc);
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
    endtask

    task automatic drive(input int sp, input int m,
                         input int kp, input int ki, input int kd);
        bus.setpoint    = sp[7:0];
        bus.measurement = m[7:0];
        bus.K_p         = kp[5:0];
        bus.K_i         = ki[5:0];
        bus.K_d         = kd[5:0];
    endtask

    // Pulse sample_req; returns gap cycles after the request cycle
    task automatic fire(input int expv, input int lat,
                        input int gap, input bit push);
        exp_t e;
        if (push) begin
            e.v = expv[7:0];
            e.c = cyc + lat;
            expq.push_back(e);
        end
        bus.sample_req = 1'b1;
        step(1);
        bus.sample_req = 1'b0;
        step(gap - 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        ena = 1'b1;
        bus.sample_req = 1'b0;
        drive(0, 0, 0, 0, 0);
        step(2);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_pid_out", int'(bus.pid_out), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_overrun", int'(bus.overrun), 0);
        step(1);

        // P only, with busy window
        drive(100, 50, 4, 0, 0);
        fire(50, 5, 1, 1);
        @(negedge clk);
        chk("busy_c1", int'(bus.busy), 1);
        step(5);
        @(negedge clk);
        chk("busy_c6", int'(bus.busy), 0);
        chk("hold_pid_out", int'(bus.pid_out), 50);
        step(2);

        // I only
        do_reset();
        drive(60, 50, 0, 4, 0);
        fire(10, 5, 8, 1);
        fire(20, 5, 8, 1);
        fire(30, 5, 8, 1);
        do_reset();
        drive(255, 0, 0, 4, 0);
        fire(255, 5, 8, 1);
        fire(255, 5, 8, 1);
        fire(255, 5, 8, 1);
        drive(0, 255, 0, 4, 0);
        fire(255, 5, 8, 1);
        fire(1, 5, 8, 1);
        fire(0, 5, 8, 1);
        fire(0, 5, 8, 1);
        fire(0, 5, 8, 1);
        drive(255, 0, 0, 4, 0);
        fire(0, 5, 8, 1);
        fire(0, 5, 8, 1);
        fire(254, 5, 8, 1);

        // D only
        do_reset();
        drive(50, 50, 0, 0, 4);
        fire(0, 5, 8, 1);
        drive(70, 50, 0, 0, 4);
        fire(20, 5, 8, 1);
        fire(0, 5, 8, 1);

        // Saturation and scaling
        do_reset();
        drive(255, 0, 63, 0, 0);
        fire(255, 5, 8, 1);
        drive(0, 200, 4, 0, 0);
        fire(0, 5, 8, 1);
        drive(255, 0, 4, 0, 0);
        fire(255, 5, 8, 1);
        drive(107, 100, 5, 0, 0);
        fire(8, 5, 8, 1);

        // All three terms, back-to-back at the minimum period
        do_reset();
        drive(60, 50, 4, 4, 4);
        fire(30, 5, 6, 1);
        drive(70, 50, 4, 4, 4);
        fire(60, 5, 8, 1);

        // Gain snapshot and overrun
        do_reset();
        drive(100, 50, 4, 0, 0);
        fire(50, 5, 2, 1);
        bus.K_p = 6'd63;
        bus.setpoint = 8'd0;
        step(1);
        bus.sample_req = 1'b1;
        ovq.push_back(cyc + 1);
        step(1);
        bus.sample_req = 1'b0;
        step(8);

        // Reset mid-computation
        do_reset();
        drive(100, 50, 4, 0, 0);
        fire(50, 5, 8, 1);
        drive(100, 50, 4, 4, 0);
        fire(0, 5, 3, 0);
        do_reset();
        @(negedge clk);
        chk("abort_pid_out", int'(bus.pid_out), 0);
        chk("abort_out_valid", int'(bus.out_valid), 0);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_overrun", int'(bus.overrun), 0);
        step(6);
        drive(60, 50, 0, 4, 0);
        fire(10, 5, 8, 1);

        // Enable stall of three cycles
        do_reset();
        drive(100, 50, 4, 0, 0);
        fire(50, 8, 2, 1);
        ena = 1'b0;
        step(3);
        ena = 1'b1;
        step(8);
        ena = 1'b0;
        bus.sample_req = 1'b1;
        step(1);
        bus.sample_req = 1'b0;
        ena = 1'b1;
        step(8);
        @(negedge clk);
        chk("ena_req_ignored_busy", int'(bus.busy), 0);

        chk("exp_queue_drained", expq.size(), 0);
        chk("ov_queue_drained", ovq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
